// File: rtl/stopwatch_pkg.sv
// Shared types and default parameters for the stopwatch controller slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SPLIT = 2'd2,
        PAUSE = 2'd3
    } sw_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_MAX        = 99;
    localparam int unsigned DEF_PRESCALE   = 4;
    localparam int unsigned DEF_LAP_DEPTH  = 4;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/lap outputs of the stopwatch controller.
interface stopwatch_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  ss_btn;
    logic                  lap_btn;
    logic                  lap_rd;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] display;
    logic                  running;
    logic                  wrap;
    logic                  lap_valid;
    logic [DATA_WIDTH-1:0] lap_data;
    logic                  lap_full;

    modport master (
        output ss_btn, lap_btn, lap_rd,
        input  count, display, running, wrap, lap_valid, lap_data, lap_full
    );

    modport slave (
        input  ss_btn, lap_btn, lap_rd,
        output count, display, running, wrap, lap_valid, lap_data, lap_full
    );
endinterface

// File: rtl/stopwatch_ctrl_lap_fifo.sv
// Show-ahead lap FIFO: dout presents the head whenever valid, zero when empty.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module lap_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      used;
    logic             do_push;
    logic             do_pop;

    assign valid   = (used != '0);
    assign full    = (used == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            used   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: used <= used;
            endcase
        end
    end

    // Storage write; contents beyond the occupancy window are don't-care.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: start/stop/split/clear FSM, prescaled
// wrap-around counter and frozen split display.
// Optional lap FIFO enabled by defining STOPWATCH_LAP_FIFO_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX        = DEF_MAX,
    parameter int unsigned PRESCALE   = DEF_PRESCALE,
    parameter int unsigned LAP_DEPTH  = DEF_LAP_DEPTH
) (
    input logic             clk,
    input logic             resetn,
    stopwatch_ctrl_if.slave bus
);
    localparam int unsigned           PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]       PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [DATA_WIDTH-1:0] CNT_MAX = DATA_WIDTH'(MAX);

    sw_state_e             state_q;
    sw_state_e             state_d;
    logic [PS_W-1:0]       prescale_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] split_q;
    logic                  wrap_q;
    logic                  active;
    logic                  tick;
    logic                  start;
    logic                  capture;
    logic                  clear;

    assign active = (state_q == RUN) || (state_q == SPLIT);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and per-cycle control strobes; ss_btn has priority over lap_btn.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        capture = 1'b0;
        clear   = 1'b0;
        tick    = active && (prescale_q == PS_LAST);
        case (state_q)
            IDLE: begin
                if (bus.ss_btn) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN, SPLIT: begin
                if (bus.ss_btn) begin
                    state_d = PAUSE;
                end else if (bus.lap_btn) begin
                    state_d = SPLIT;
                    capture = 1'b1;
                end
            end
            PAUSE: begin
                if (bus.ss_btn) begin
                    state_d = RUN;
                end else if (bus.lap_btn) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler, count, split capture and wrap pulse; the current state governs the tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescale_q <= '0;
            count_q    <= '0;
            split_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= tick && (count_q == CNT_MAX);
            if (capture) split_q <= count_q;
            if (clear) begin
                prescale_q <= '0;
                count_q    <= '0;
            end else begin
                if (start) begin
                    prescale_q <= '0;
                end else if (active) begin
                    prescale_q <= tick ? '0 : prescale_q + PS_W'(1);
                end
                if (tick) begin
                    count_q <= (count_q == CNT_MAX) ? '0 : count_q + DATA_WIDTH'(1);
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.display = (state_q == SPLIT) ? split_q : count_q;
    assign bus.running = active;
    assign bus.wrap    = wrap_q;

`ifdef STOPWATCH_LAP_FIFO_EN
    lap_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (capture),
        .pop    (bus.lap_rd),
        .flush  (clear),
        .din    (count_q),
        .dout   (bus.lap_data),
        .valid  (bus.lap_valid),
        .full   (bus.lap_full)
    );
`else
    assign bus.lap_data  = '0;
    assign bus.lap_valid = 1'b0;
    assign bus.lap_full  = 1'b0;
`endif
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch counter datapath. Turns two single-cycle button pulses into start, stop, split and clear control, using a four-state machine. Owns the prescaled tick that advances the wrap-around count and the frozen split display. Optionally buffers captured lap times in a small FIFO for a downstream reader.

## Interface
- DATA_WIDTH, 16, width of count, display and lap_data
- MAX, 99, terminal count value; count wraps MAX -> 0; MAX < 2^DATA_WIDTH
- PRESCALE, 4, clk cycles per count tick; must be >= 1
- LAP_DEPTH, 4, lap FIFO entries; power of two, >= 2
- clk  input  1  clock; all state changes on the rising edge
- resetn  input  1  asynchronous, active-low reset
- ss_btn  input  1  start/stop pulse; sampled each cycle
- lap_btn  input  1  lap/split/clear pulse; sampled each cycle
- lap_rd  input  1  pop the lap FIFO head
- count  output  DATA_WIDTH  live count
- display  output  DATA_WIDTH  value to show: live count, or frozen capture in SPLIT
- running  output  1  high in RUN or SPLIT
- wrap  output  1  one-cycle pulse in the cycle after count goes MAX -> 0
- lap_valid  output  1  FIFO non-empty; lap_data is valid
- lap_data  output  DATA_WIDTH  FIFO head (show-ahead)
- lap_full  output  1  FIFO full

## Operation
- States: IDLE, RUN, SPLIT, PAUSE.
- Priority: ss_btn beats lap_btn. When both are high, lap_btn is ignored.
- IDLE:
  - ss_btn -> RUN, with prescaler cleared.
  - lap_btn is ignored.
- RUN:
  - ss_btn -> PAUSE.
  - lap_btn -> SPLIT. Captures the current count into the split register and pushes it to the FIFO.
- SPLIT:
  - Counting continues; display holds the split register.
  - lap_btn -> stays in SPLIT. Recaptures and pushes the current count.
  - ss_btn -> PAUSE.
- PAUSE:
  - Count and prescaler hold.
  - ss_btn -> RUN; the tick phase is preserved.
  - lap_btn -> IDLE. Clears count and prescaler and flushes the FIFO.
- Tick rules:
  - Tick when the current state is RUN or SPLIT and prescaler == PRESCALE-1. The prescaler then returns to 0; otherwise it increments.
  - On tick: count <= (count == MAX) ? 0 : count+1.
  - A tick due in the cycle ss_btn is sampled still takes effect, because the current state governs.
- display equals count in IDLE, RUN and PAUSE, and equals the split register in SPLIT.
- Lap capture uses count as it was before that edge's tick update.
- FIFO rules:
  - Push when full and no pop: the value is dropped; contents are unchanged.
  - Push and pop in the same cycle when full: both are accepted.
  - lap_rd with lap_valid low is ignored.
  - Push and lap_rd together when empty: the push is accepted and lap_rd is ignored.
- Reset state: IDLE, count 0, prescaler 0, split register 0, display 0, running 0, wrap 0, FIFO empty, lap_valid 0, lap_full 0, lap_data 0.

## Timing
- All outputs are registered or decoded from registered state only; no input-to-output combinational paths.
- ss_btn sampled at edge E in IDLE: running is high after E, and count = 1 after edge E+PRESCALE.
- A lap push sampled at edge E with the FIFO empty: lap_valid and lap_data are valid after E.
- lap_rd sampled at edge E: the next entry (or lap_valid low) appears after E.
- wrap is high for exactly one cycle, coincident with the count == 0 that follows MAX.
- Reset mid-operation immediately forces all reset values; FIFO contents are lost.

## Configuration
- Macro STOPWATCH_LAP_FIFO_EN.
- Defined: the lap FIFO is instantiated as described above.
- Undefined:
  - No FIFO storage.
  - lap_valid, lap_full and lap_data are tied to 0, and lap_rd is ignored.
  - Split capture and display freeze behave identically.

## Structure
- Package stopwatch_pkg holds:
  - Enum sw_state_e: IDLE=2'd0, RUN=2'd1, SPLIT=2'd2, PAUSE=2'd3.
  - Default parameter constants.
- Sub-module lap_fifo, parameterized by width and depth:
  - Ports: push, pop, flush, data in, data out, valid, full.
  - Uses a show-ahead read.
  - Instantiated only under STOPWATCH_LAP_FIFO_EN.

## Test plan
- Run from reset with PRESCALE=4 and ss_btn held one cycle: count reaches 1 after 4 edges and 3 after 12; running = 1.
- MAX=5, PRESCALE=1, run 7 ticks: count sequence 1,2,3,4,5,0,1; wrap pulses exactly once, with count = 0.
- Pause at count 7 with prescaler phase 2, hold 10 cycles, resume: count stays 7 while paused; it reaches 8 two edges after the resume edge.
- From RUN at count 3, lap_btn; a later lap_btn at count 9: state SPLIT; display shows 3, then 9, while count keeps advancing; FIFO holds 3 then 9; lap_rd pops 3 then 9, then lap_valid = 0.
- LAP_DEPTH=4, push 5 laps without reading: lap_full = 1; the fifth value is dropped; reads return the first four values in order.
- From PAUSE, ss_btn and lap_btn together -> RUN with the FIFO intact. Then from PAUSE, lap_btn -> IDLE with count 0, FIFO empty, display 0. Then assert resetn = 0 mid-RUN -> all outputs return to reset values asynchronously.
